// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of the single data_memory port.
// Each access runs IDLE -> ISSUE -> (WAIT) -> RESP with one idle bubble after.
module data_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              busy,
    output logic              owner
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_owner;
    logic          wr;
    logic [CW-1:0] cnt;
    logic          do_grant;
    logic          grant;
    logic          capture;

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        grant     = 1'b0;
        capture   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    do_grant  = 1'b1;
                    state_nxt = S_ISSUE;
                    if (m0_req && m1_req)
                        grant = (FIXED_PRIO != 0) ? 1'b0 : !last_owner;
                    else
                        grant = m1_req;
                end
            end
            S_ISSUE: begin
                if (wr || READ_LATENCY == 1) begin
                    state_nxt = S_RESP;
                    capture   = !wr;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = S_RESP;
                    capture   = 1'b1;
                end
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            wr            <= 1'b0;
            cnt           <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
            m0_readdata   <= '0;
            m1_readdata   <= '0;
        end else if (clk_enable) begin
            state <= state_nxt;
            if (do_grant) begin
                owner         <= grant;
                wr            <= grant ? m1_write : m0_write;
                mem_address   <= grant ? m1_address : m0_address;
                mem_writedata <= grant ? m1_writedata : m0_writedata;
            end
            if (state == S_ISSUE)
                cnt <= CW'(READ_LATENCY - 1);
            else if (state == S_WAIT)
                cnt <= cnt - CW'(1);
            // Read data lands in the owner's register on the edge entering RESP
            if (capture) begin
                if (owner)
                    m1_readdata <= mem_readdata;
                else
                    m0_readdata <= mem_readdata;
            end
            if (state == S_RESP)
                last_owner <= owner;
        end
    end

    assign mem_write = clk_enable && (state == S_ISSUE) && wr;
    assign mem_read  = clk_enable && (state == S_ISSUE) && !wr;
    assign m0_ready  = clk_enable && (state == S_RESP) && !owner;
    assign m1_ready  = clk_enable && (state == S_RESP) && owner;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: instance 0 is round-robin with latency 1,
// instance 1 is fixed-priority with latency 3.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        preload;

    logic        m0_req[2], m0_write[2], m0_ready[2];
    logic        m1_req[2], m1_write[2], m1_ready[2];
    logic [31:0] m0_address[2], m0_writedata[2], m0_readdata[2];
    logic [31:0] m1_address[2], m1_writedata[2], m1_readdata[2];
    logic [31:0] mem_address[2], mem_writedata[2], mem_readdata[2];
    logic        mem_write[2], mem_read[2], busy[2], owner[2];

    logic [31:0] mem0[256];
    logic [31:0] mem1[256];

    int n_cmp = 0;
    int n_err = 0;
    int both_cnt = 0;
    int rd_cnt, wr_cnt, idle_cnt;
    logic [31:0] strobe_addr, strobe_data;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .READ_LATENCY(1), .FIXED_PRIO(0)
    ) u0 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .m0_req(m0_req[0]), .m0_write(m0_write[0]),
        .m0_address(m0_address[0]), .m0_writedata(m0_writedata[0]),
        .m0_readdata(m0_readdata[0]), .m0_ready(m0_ready[0]),
        .m1_req(m1_req[0]), .m1_write(m1_write[0]),
        .m1_address(m1_address[0]), .m1_writedata(m1_writedata[0]),
        .m1_readdata(m1_readdata[0]), .m1_ready(m1_ready[0]),
        .mem_address(mem_address[0]), .mem_writedata(mem_writedata[0]),
        .mem_write(mem_write[0]), .mem_read(mem_read[0]),
        .mem_readdata(mem_readdata[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    data_mem_arbiter #(
        .READ_LATENCY(3), .FIXED_PRIO(1)
    ) u1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .m0_req(m0_req[1]), .m0_write(m0_write[1]),
        .m0_address(m0_address[1]), .m0_writedata(m0_writedata[1]),
        .m0_readdata(m0_readdata[1]), .m0_ready(m0_ready[1]),
        .m1_req(m1_req[1]), .m1_write(m1_write[1]),
        .m1_address(m1_address[1]), .m1_writedata(m1_writedata[1]),
        .m1_readdata(m1_readdata[1]), .m1_ready(m1_ready[1]),
        .mem_address(mem_address[1]), .mem_writedata(mem_writedata[1]),
        .mem_write(mem_write[1]), .mem_read(mem_read[1]),
        .mem_readdata(mem_readdata[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    // Memory model: combinational read of the held address, write on clock
    assign mem_readdata[0] = mem0[mem_address[0][7:0]];
    assign mem_readdata[1] = mem1[mem_address[1][7:0]];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) begin
                mem0[k] <= 32'h0;
                mem1[k] <= 32'h0;
            end
            mem1[8'h10] <= 32'h1111_1111;
            mem1[8'h20] <= 32'hCAFE_F00D;
        end else begin
            if (mem_write[0]) mem0[mem_address[0][7:0]] <= mem_writedata[0];
            if (mem_write[1]) mem1[mem_address[1][7:0]] <= mem_writedata[1];
        end
    end

    always @(negedge clk) begin
        if (mem_read[0] && mem_write[0]) both_cnt++;
        if (mem_read[1] && mem_write[1]) both_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int i, output int lat, output logic who);
        lat = 0;
        who = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
        idle_cnt = 0;
        strobe_addr = '0;
        strobe_data = '0;
        do begin
            @(negedge clk);
            lat++;
            if (!busy[i]) idle_cnt++;
            if (mem_read[i]) rd_cnt++;
            if (mem_write[i]) wr_cnt++;
            if (mem_read[i] || mem_write[i]) begin
                strobe_addr = mem_address[i];
                strobe_data = mem_writedata[i];
            end
        end while (!(m0_ready[i] || m1_ready[i]) && lat < 30);
        if (!(m0_ready[i] || m1_ready[i]))
            chk("wait_timeout", 32'd1, 32'd0);
        who = m1_ready[i];
    endtask

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        logic        own;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m0_req[i] = 0; m0_write[i] = 0;
            m0_address[i] = '0; m0_writedata[i] = '0;
            m1_req[i] = 0; m1_write[i] = 0;
            m1_address[i] = '0; m1_writedata[i] = '0;
        end
    endtask

    initial begin
        int   lat;
        logic who;
        logic w;

        vecs[0] = '{1,0,1,0, 32'h10,0, 32'hDEADBEEF,0, 0, 0};
        vecs[1] = '{1,0,0,0, 32'h10,0, 0,0, 0, 32'hDEADBEEF};
        vecs[2] = '{0,1,0,1, 0,32'h20, 0,32'h12345678, 1, 0};
        vecs[3] = '{1,1,0,0, 32'h10,32'h20, 0,0, 0, 32'hDEADBEEF};
        vecs[4] = '{1,1,0,0, 32'h10,32'h20, 0,0, 1, 32'h12345678};
        vecs[5] = '{1,1,1,1, 32'h30,32'h40,
                    32'hA5A5A5A5,32'h5A5A5A5A, 0, 0};
        vecs[6] = '{0,1,0,0, 0,32'h30, 0,0, 1, 32'hA5A5A5A5};
        vecs[7] = '{1,0,0,0, 32'h40,0, 0,0, 0, 32'h0};
        vecs[8] = '{0,1,0,0, 0,32'h20, 0,0, 1, 32'h12345678};

        clear_inputs();
        reset = 0;
        clk_enable = 1;
        preload = 1;
        repeat (3) @(negedge clk);
        preload = 0;

        chk("rst_busy", {31'b0, busy[0]}, 0);
        chk("rst_owner", {31'b0, owner[0]}, 0);
        chk("rst_addr", mem_address[0], 0);
        chk("rst_wdata", mem_writedata[0], 0);
        chk("rst_rd0", m0_readdata[0], 0);
        chk("rst_rd1", m1_readdata[0], 0);
        chk("rst_strobe", {30'b0, mem_read[0], mem_write[0]}, 0);
        chk("rst_ready", {30'b0, m0_ready[0], m1_ready[0]}, 0);
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            m0_req[0] = vecs[i].r0; m0_write[0] = vecs[i].w0;
            m0_address[0] = vecs[i].a0; m0_writedata[0] = vecs[i].d0;
            m1_req[0] = vecs[i].r1; m1_write[0] = vecs[i].w1;
            m1_address[0] = vecs[i].a1; m1_writedata[0] = vecs[i].d1;
            w = vecs[i].own ? vecs[i].w1 : vecs[i].w0;
            wait_ready(0, lat, who);
            chk($sformatf("v%0d_owner", i), {31'b0, who},
                {31'b0, vecs[i].own});
            chk($sformatf("v%0d_both_rdy", i),
                {31'b0, m0_ready[0] && m1_ready[0]}, 0);
            chk($sformatf("v%0d_lat", i), lat, 2);
            chk($sformatf("v%0d_wr_cnt", i), wr_cnt, {31'b0, w});
            chk($sformatf("v%0d_rd_cnt", i), rd_cnt, {31'b0, !w});
            chk($sformatf("v%0d_addr", i), strobe_addr,
                vecs[i].own ? vecs[i].a1 : vecs[i].a0);
            if (w)
                chk($sformatf("v%0d_wdata", i), strobe_data,
                    vecs[i].own ? vecs[i].d1 : vecs[i].d0);
            else
                chk($sformatf("v%0d_rdata", i),
                    vecs[i].own ? m1_readdata[0] : m0_readdata[0],
                    vecs[i].rdata);
            clear_inputs();
            @(negedge clk);
        end

        // Continuous contention from reset: strict alternation
        reset = 0;
        m0_req[0] = 1; m0_address[0] = 32'h10;
        m1_req[0] = 1; m1_address[0] = 32'h20;
        @(negedge clk);
        reset = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(0, lat, who);
            chk($sformatf("rr%0d_owner", k), {31'b0, who}, k % 2);
            if (k > 0)
                chk($sformatf("rr%0d_idle", k), idle_cnt, 1);
            chk($sformatf("rr%0d_data", k),
                who ? m1_readdata[0] : m0_readdata[0],
                (k % 2) ? 32'h12345678 : 32'hDEADBEEF);
        end
        clear_inputs();
        @(negedge clk);

        // Enable dropped while in ISSUE
        m0_req[0] = 1; m0_address[0] = 32'h30;
        @(negedge clk);
        chk("en_issue_rd", {31'b0, mem_read[0]}, 1);
        clk_enable = 0;
        #1;
        chk("en_off_rd", {31'b0, mem_read[0]}, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("en_off%0d", k),
                {29'b0, mem_read[0], m0_ready[0], busy[0]}, 32'h1);
        end
        clk_enable = 1;
        #1;
        chk("en_on_rd", {31'b0, mem_read[0]}, 1);
        chk("en_on_addr", mem_address[0], 32'h30);
        wait_ready(0, lat, who);
        chk("en_lat", lat, 1);
        chk("en_owner", {31'b0, who}, 0);
        chk("en_data", m0_readdata[0], 32'hA5A5A5A5);
        clear_inputs();
        @(negedge clk);

        // Reset in WAIT on the latency-3 instance
        m1_req[1] = 1; m1_address[1] = 32'h20;
        @(negedge clk);
        chk("rw_issue_rd", {31'b0, mem_read[1]}, 1);
        @(negedge clk);
        chk("rw_wait", {30'b0, busy[1], mem_read[1]}, 32'h2);
        reset = 0;
        #1;
        chk("rw_rst_now",
            {29'b0, mem_read[1], m1_ready[1], busy[1]}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rw_rst%0d_rdy", k), {31'b0, m1_ready[1]}, 0);
        end
        chk("rw_rd1_kept0", m1_readdata[1], 0);
        reset = 1;
        wait_ready(1, lat, who);
        chk("rw_after_lat", lat, 4);
        chk("rw_after_owner", {31'b0, who}, 1);
        chk("rw_after_data", m1_readdata[1], 32'hCAFEF00D);
        clear_inputs();
        @(negedge clk);

        // Fixed priority: requester 0 wins until it lets go
        m0_req[1] = 1; m0_address[1] = 32'h10;
        m1_req[1] = 1; m1_address[1] = 32'h20;
        for (int k = 0; k < 3; k++) begin
            wait_ready(1, lat, who);
            chk($sformatf("fp%0d_owner", k), {31'b0, who}, 0);
            chk($sformatf("fp%0d_lat", k), lat, (k == 0) ? 4 : 5);
            chk($sformatf("fp%0d_data", k), m0_readdata[1],
                32'h11111111);
        end
        m0_req[1] = 0;
        wait_ready(1, lat, who);
        chk("fp_m1_owner", {31'b0, who}, 1);
        chk("fp_m1_data", m1_readdata[1], 32'hCAFEF00D);
        clear_inputs();
        @(negedge clk);

        chk("both_strobes", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
